// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Round-robin arbiter sharing the single-port 512x16 signed data memory
//   between the calculator core (requester 0) and the keypad/display I/O
//   engine (requester 1). Each granted request gets exactly one ACCESS
//   cycle. The ACK pulse and the result follow on the next rising edge.
//
// Ports
//   CLK              system clock (arbiter on rising edge, memory writes on falling edge)
//   RST              asynchronous active-low reset
//   REQn/WEn/ADDRn/WDATAn   request, write flag, word address and write data of requester n
//   ACKn             one-cycle completion pulse for requester n
//   RDATAn           read result (or echoed write data), held until requester n's next ACK
//   MEM_EN/MEM_ADDR/MEM_IN  memory write enable, address and write data
//   MEM_OUT          combinational memory read data
//   BUSY             high while an access is in progress
module data_mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic                 WE0,
  input  logic                 WE1,
  input  logic        [AW-1:0] ADDR0,
  input  logic        [AW-1:0] ADDR1,
  input  logic signed [DW-1:0] WDATA0,
  input  logic signed [DW-1:0] WDATA1,
  output logic                 ACK0,
  output logic                 ACK1,
  output logic signed [DW-1:0] RDATA0,
  output logic signed [DW-1:0] RDATA1,
  output logic                 MEM_EN,
  output logic        [AW-1:0] MEM_ADDR,
  output logic signed [DW-1:0] MEM_IN,
  input  logic signed [DW-1:0] MEM_OUT,
  output logic                 BUSY
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state;
  logic   owner;
  logic   prio;
  logic   we_l;

  logic   finishing;
  logic   elig0;
  logic   elig1;
  logic   prio_nxt;
  logic   winner;

  // The owner of a finishing access is masked at the edge that raises its
  // ACK: its REQ is still the one just served. A REQ still high after that
  // edge is taken as a fresh request, which gives a lone requester one
  // access every two cycles and two requesters strict alternation.
  always_comb begin
    finishing = (state == ACCESS);
    elig0     = REQ0 & ~(finishing & ~owner);
    elig1     = REQ1 & ~(finishing & owner);
    prio_nxt  = finishing ? ~owner : prio;
    winner    = (elig0 & elig1) ? prio_nxt : elig1;
  end

  // Write strobe exists only while in ACCESS, so a reset that forces IDLE
  // before the falling edge also cancels the pending write.
  assign MEM_EN = finishing & we_l;
  assign BUSY   = finishing;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      owner    <= 1'b0;
      prio     <= 1'b0;
      we_l     <= 1'b0;
      MEM_ADDR <= '0;
      MEM_IN   <= '0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      RDATA0   <= '0;
      RDATA1   <= '0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;

      // Completion of the current access
      if (state == ACCESS) begin
        prio <= ~owner;
        if (!owner) begin
          ACK0   <= 1'b1;
          RDATA0 <= we_l ? MEM_IN : MEM_OUT;
        end else begin
          ACK1   <= 1'b1;
          RDATA1 <= we_l ? MEM_IN : MEM_OUT;
        end
      end

      // Grant for the next cycle, applied in the same edge (no idle gap)
      if (elig0 | elig1) begin
        state <= ACCESS;
        owner <= winner;
        if (winner) begin
          we_l     <= WE1;
          MEM_ADDR <= ADDR1;
          MEM_IN   <= WDATA1;
        end else begin
          we_l     <= WE0;
          MEM_ADDR <= ADDR0;
          MEM_IN   <= WDATA0;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic               CLK;
  logic               RST;
  logic               REQ0, REQ1, WE0, WE1;
  logic        [8:0]  ADDR0, ADDR1;
  logic signed [15:0] WDATA0, WDATA1;
  logic               ACK0, ACK1;
  logic signed [15:0] RDATA0, RDATA1;
  logic               MEM_EN;
  logic        [8:0]  MEM_ADDR;
  logic signed [15:0] MEM_IN;
  logic signed [15:0] MEM_OUT;
  logic               BUSY;

  logic signed [15:0] ram [512];

  int tests_run = 0;
  int fails     = 0;

  data_mem_arbiter #(.AW(9), .DW(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_IN(MEM_IN),
    .MEM_OUT(MEM_OUT), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Data memory model: preset contents, write on falling edge, async read
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'(i + 100);
    forever begin
      @(negedge CLK);
      if (MEM_EN) ram[MEM_ADDR] = MEM_IN;
    end
  end
  assign MEM_OUT = ram[MEM_ADDR];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    // Outputs while held in reset
    cyc; cyc;
    tests_run++; if (ACK0 !== 1'b0 || ACK1 !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b%b want 00", ACK0, ACK1); end
    tests_run++; if (RDATA0 !== 16'sd0 || RDATA1 !== 16'sd0) begin fails++; $display("FAIL rst_rdata: got %0d/%0d want 0/0", RDATA0, RDATA1); end
    tests_run++; if (MEM_EN !== 1'b0 || MEM_ADDR !== 9'd0 || MEM_IN !== 16'sd0 || BUSY !== 1'b0) begin fails++; $display("FAIL rst_mem: en=%b addr=%0d in=%0d busy=%b want 0 0 0 0", MEM_EN, MEM_ADDR, MEM_IN, BUSY); end
    RST = 1'b1;
    cyc;
    // Write to 5 interrupted by reset before the falling edge
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd5; WDATA0 = -16'sd3;
    cyc;
    tests_run++; if (BUSY !== 1'b1 || MEM_EN !== 1'b1) begin fails++; $display("FAIL rst_pre_busy: busy=%b en=%b want 1 1", BUSY, MEM_EN); end
    #1 RST = 1'b0;
    #1;
    tests_run++; if (BUSY !== 1'b0 || MEM_EN !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: busy=%b en=%b want 0 0", BUSY, MEM_EN); end
    tests_run++; if (MEM_ADDR !== 9'd0 || MEM_IN !== 16'sd0) begin fails++; $display("FAIL rst_mid_mem: addr=%0d in=%0d want 0 0", MEM_ADDR, MEM_IN); end
    REQ0 = 1'b0; WE0 = 1'b0;
    @(negedge CLK); #1;
    tests_run++; if (ram[5] !== 16'sd105) begin fails++; $display("FAIL rst_nowrite: ram[5]=%0d want 105", ram[5]); end
    cyc;
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc;
      tests_run++; if (ACK0 !== 1'b0) begin fails++; $display("FAIL rst_noack: ACK0=%b want 0", ACK0); end
    end
  endtask

  task automatic test_single;
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd9; WDATA0 = 16'sh8001;
    cyc;
    tests_run++; if (BUSY !== 1'b1 || MEM_EN !== 1'b1 || MEM_ADDR !== 9'd9 || MEM_IN !== 16'sh8001) begin fails++; $display("FAIL single_grant: busy=%b en=%b addr=%0d in=%0d want 1 1 9 -32767", BUSY, MEM_EN, MEM_ADDR, MEM_IN); end
    tests_run++; if (ACK0 !== 1'b0) begin fails++; $display("FAIL single_early_ack: ACK0=%b want 0", ACK0); end
    cyc;
    tests_run++; if (ACK0 !== 1'b1 || RDATA0 !== 16'sh8001 || BUSY !== 1'b0) begin fails++; $display("FAIL single_wr_ack: ack=%b rdata=%0d busy=%b want 1 -32767 0", ACK0, RDATA0, BUSY); end
    tests_run++; if (ram[9] !== 16'sh8001) begin fails++; $display("FAIL single_wr_mem: ram[9]=%0d want -32767", ram[9]); end
    REQ0 = 1'b0;
    cyc;
    tests_run++; if (ACK0 !== 1'b0 || BUSY !== 1'b0) begin fails++; $display("FAIL single_idle: ack=%b busy=%b want 0 0", ACK0, BUSY); end
    REQ0 = 1'b1; WE0 = 1'b0; WDATA0 = 16'sd0;
    cyc;
    tests_run++; if (BUSY !== 1'b1 || MEM_EN !== 1'b0) begin fails++; $display("FAIL single_rd_grant: busy=%b en=%b want 1 0", BUSY, MEM_EN); end
    cyc;
    tests_run++; if (ACK0 !== 1'b1 || RDATA0 !== -16'sd32767) begin fails++; $display("FAIL single_rd_ack: ack=%b rdata=%0d want 1 -32767", ACK0, RDATA0); end
    tests_run++; if (RDATA1 !== 16'sd0 || ACK1 !== 1'b0) begin fails++; $display("FAIL single_rdata1: rdata1=%0d ack1=%b want 0 0", RDATA1, ACK1); end
    REQ0 = 1'b0;
    cyc;
  endtask

  task automatic test_simultaneous;
    RST = 1'b0;
    cyc;
    RST = 1'b1;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 9'd1;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 9'd2;
    cyc;
    tests_run++; if (BUSY !== 1'b1 || MEM_ADDR !== 9'd1 || MEM_EN !== 1'b0) begin fails++; $display("FAIL sim_first: busy=%b addr=%0d en=%b want 1 1 0", BUSY, MEM_ADDR, MEM_EN); end
    cyc;
    tests_run++; if (ACK0 !== 1'b1 || ACK1 !== 1'b0 || RDATA0 !== 16'sd101) begin fails++; $display("FAIL sim_ack0: ack=%b%b rdata0=%0d want 10 101", ACK0, ACK1, RDATA0); end
    tests_run++; if (BUSY !== 1'b1 || MEM_ADDR !== 9'd2) begin fails++; $display("FAIL sim_second: busy=%b addr=%0d want 1 2", BUSY, MEM_ADDR); end
    REQ0 = 1'b0;
    cyc;
    tests_run++; if (ACK1 !== 1'b1 || ACK0 !== 1'b0 || RDATA1 !== 16'sd102 || RDATA0 !== 16'sd101) begin fails++; $display("FAIL sim_ack1: ack=%b%b rdata=%0d/%0d want 01 101/102", ACK0, ACK1, RDATA0, RDATA1); end
    REQ1 = 1'b0;
    tests_run++; if (BUSY !== 1'b0) begin fails++; $display("FAIL sim_idle: busy=%b want 0", BUSY); end
    cyc;
  endtask

  task automatic test_contention;
    int i0 = 0;
    int i1 = 0;
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd100; WDATA0 = 16'sd1000;
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 9'd200; WDATA1 = -16'sd2000;
    cyc;
    for (int k = 0; k < 8; k++) begin
      cyc;
      tests_run++;
      if (ACK0 !== (k % 2 == 0) || ACK1 !== (k % 2 == 1)) begin
        fails++; $display("FAIL cont_order[%0d]: ack=%b%b want %b%b", k, ACK0, ACK1, (k % 2 == 0), (k % 2 == 1));
      end
      if (k % 2 == 0) begin
        i0++;
        if (i0 < 4) begin ADDR0 = 9'(100 + i0); WDATA0 = 16'(1000 + i0); end
        else REQ0 = 1'b0;
      end else begin
        i1++;
        if (i1 < 4) begin ADDR1 = 9'(200 + i1); WDATA1 = -16'(2000 + i1); end
        else REQ1 = 1'b0;
      end
    end
    tests_run++; if (RDATA0 !== 16'sd1003 || RDATA1 !== -16'sd2003) begin fails++; $display("FAIL cont_rdata: %0d/%0d want 1003/-2003", RDATA0, RDATA1); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (ram[100 + i] !== 16'(1000 + i)) begin fails++; $display("FAIL cont_mem0[%0d]: %0d want %0d", i, ram[100 + i], 1000 + i); end
      tests_run++; if (ram[200 + i] !== -16'(2000 + i)) begin fails++; $display("FAIL cont_mem1[%0d]: %0d want %0d", i, ram[200 + i], -(2000 + i)); end
    end
    cyc;
    tests_run++; if (BUSY !== 1'b0) begin fails++; $display("FAIL cont_idle: busy=%b want 0", BUSY); end
  endtask

  task automatic test_masking;
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 9'd300; WDATA1 = 16'sd77;
    for (int k = 0; k < 8; k++) begin
      cyc;
      tests_run++;
      if (BUSY !== (k % 2 == 0) || ACK1 !== (k % 2 == 1) || MEM_EN !== (k % 2 == 0)) begin
        fails++; $display("FAIL mask[%0d]: busy=%b ack1=%b en=%b want %b %b %b", k, BUSY, ACK1, MEM_EN, (k % 2 == 0), (k % 2 == 1), (k % 2 == 0));
      end
    end
    REQ1 = 1'b0;
    tests_run++; if (ram[300] !== 16'sd77 || RDATA1 !== 16'sd77 || ACK0 !== 1'b0) begin fails++; $display("FAIL mask_data: ram=%0d rdata1=%0d ack0=%b want 77 77 0", ram[300], RDATA1, ACK0); end
    cyc;
    tests_run++; if (BUSY !== 1'b0 || MEM_EN !== 1'b0) begin fails++; $display("FAIL mask_idle: busy=%b en=%b want 0 0", BUSY, MEM_EN); end
  endtask

  task automatic test_boundary;
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd0;   WDATA0 = 16'sd32767;
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 9'd511; WDATA1 = -16'sd32768;
    cyc;
    cyc;
    REQ0 = 1'b0;
    tests_run++; if (ACK0 !== 1'b1 || RDATA0 !== 16'sd32767) begin fails++; $display("FAIL bnd_wr0: ack0=%b rdata0=%0d want 1 32767", ACK0, RDATA0); end
    cyc;
    REQ1 = 1'b0;
    tests_run++; if (ACK1 !== 1'b1 || RDATA1 !== -16'sd32768) begin fails++; $display("FAIL bnd_wr1: ack1=%b rdata1=%0d want 1 -32768", ACK1, RDATA1); end
    tests_run++; if (ram[0] !== 16'sd32767 || ram[511] !== -16'sd32768) begin fails++; $display("FAIL bnd_mem: ram[0]=%0d ram[511]=%0d want 32767 -32768", ram[0], ram[511]); end
    cyc;
    // Cross read-back: each requester reads the other's location
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 9'd511; WDATA0 = 16'sd0;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 9'd0;   WDATA1 = 16'sd0;
    cyc;
    cyc;
    REQ0 = 1'b0;
    tests_run++; if (ACK0 !== 1'b1 || RDATA0 !== -16'sd32768) begin fails++; $display("FAIL bnd_rd0: ack0=%b rdata0=%0d want 1 -32768", ACK0, RDATA0); end
    tests_run++; if (RDATA1 !== -16'sd32768) begin fails++; $display("FAIL bnd_hold1: rdata1=%0d want -32768", RDATA1); end
    cyc;
    REQ1 = 1'b0;
    tests_run++; if (ACK1 !== 1'b1 || RDATA1 !== 16'sd32767) begin fails++; $display("FAIL bnd_rd1: ack1=%b rdata1=%0d want 1 32767", ACK1, RDATA1); end
    tests_run++; if (RDATA0 !== -16'sd32768) begin fails++; $display("FAIL bnd_hold0: rdata0=%0d want -32768", RDATA0); end
    cyc;
  endtask

  initial begin
    RST = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    test_reset;
    test_single;
    test_simultaneous;
    test_contention;
    test_masking;
    test_boundary;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
